dense_layer_scheduler: RTL and testbench

Sequences one dense layer through the dense-layer pipeline. On `start`, it issues one row-descriptor beat per weight row: layer index, row index, dense type and activation type. The beats go into the pipeline front, which is the delay-register bundle feeding the dense unit. Issue is credit-limited: at most `max_inflight` rows are outstanding until their results return from the pipeline tail. `done` pulses once the last row has returned.

---
 rtl/dense_layer_scheduler.sv | 83 ++++++++
 tb/tb_dense_layer_scheduler.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dense_layer_scheduler.sv
// dense_layer_scheduler: issues one descriptor beat per weight row of a dense layer, credit-limited by returning results
// Ports: clk/reset (sync, active-high); start + layer_index/row_count/dense_type/act_type are latched when IDLE;
// issue_valid/issue_ready handshake carries w_layer_index/w_row_index/dense_type_out/act_type_out to the pipeline front;
// result_valid marks a row returning from the pipeline tail; busy, done (one-cycle pulse), inflight (outstanding rows).
// Optional macro DENSE_SCHED_ERR_EN adds a sticky err output flagging returns with nothing outstanding or while IDLE.
module dense_layer_scheduler #(
  parameter int dense_type_size = 4,
  parameter int act_type_size = 4,
  parameter int max_inflight = 4,
  localparam int cnt_w = $clog2(max_inflight + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [31:0]                layer_index,
  input  logic [31:0]                row_count,
  input  logic [dense_type_size-1:0] dense_type,
  input  logic [act_type_size-1:0]   act_type,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [31:0]                w_layer_index,
  output logic [31:0]                w_row_index,
  output logic [dense_type_size-1:0] dense_type_out,
  output logic [act_type_size-1:0]   act_type_out,
  input  logic                       result_valid,
  output logic                       busy,
  output logic                       done,
  output logic [cnt_w-1:0]           inflight
`ifdef DENSE_SCHED_ERR_EN
  ,output logic                      err
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam logic [cnt_w-1:0] max_c = cnt_w'(max_inflight);
  state_t state;
  logic [31:0] row_cnt;
  logic fire, last;
  logic [cnt_w-1:0] inflight_n;
  assign issue_valid = state == ISSUE && inflight < max_c;
  assign fire = issue_valid && issue_ready;
  assign last = w_row_index == row_cnt - 32'd1;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // a return with nothing outstanding is dropped so the counter floors at zero
  always_comb inflight_n = fire && !result_valid ? inflight + cnt_w'(1)
                         : !fire && result_valid && inflight != '0 ? inflight - cnt_w'(1)
                         : inflight;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      row_cnt <= '0;
      w_layer_index <= '0;
      w_row_index <= '0;
      dense_type_out <= '0;
      act_type_out <= '0;
      inflight <= '0;
    end else begin
      inflight <= inflight_n;
      case (state)
        IDLE: if (start) begin
          row_cnt <= row_count;
          w_layer_index <= layer_index;
          w_row_index <= '0;
          dense_type_out <= dense_type;
          act_type_out <= act_type;
          state <= row_count == '0 ? DONE : ISSUE;
        end
        // the row index is not advanced past the final row so it holds its last issued value
        ISSUE: if (fire) begin
          if (last) state <= DRAIN;
          else w_row_index <= w_row_index + 32'd1;
        end
        DRAIN: if (inflight_n == '0) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef DENSE_SCHED_ERR_EN
  always_ff @(posedge clk)
    if (reset) err <= 1'b0;
    else if (result_valid && (inflight == '0 || state == IDLE)) err <= 1'b1;
`endif
endmodule

// File: tb/tb_dense_layer_scheduler.sv
// tb_dense_layer_scheduler: directed self-checking bench for dense_layer_scheduler
module tb_dense_layer_scheduler;
  logic clk = 1'b0;
  logic reset, start, issue_ready, result_valid;
  logic [31:0] layer_index, row_count;
  logic [3:0] dense_type, act_type;
  logic issue_valid, busy, done;
  logic [31:0] w_layer_index, w_row_index;
  logic [3:0] dense_type_out, act_type_out;
  logic [2:0] inflight;
`ifdef DENSE_SCHED_ERR_EN
  logic err;
`endif
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  dense_layer_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .layer_index(layer_index), .row_count(row_count),
    .dense_type(dense_type), .act_type(act_type), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .w_layer_index(w_layer_index), .w_row_index(w_row_index), .dense_type_out(dense_type_out),
    .act_type_out(act_type_out), .result_valid(result_valid), .busy(busy), .done(done), .inflight(inflight)
`ifdef DENSE_SCHED_ERR_EN
    , .err(err)
`endif
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, " issue_valid"}, 32'(issue_valid), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " inflight"}, 32'(inflight), 0);
    chk({tag, " w_layer_index"}, w_layer_index, 0);
    chk({tag, " w_row_index"}, w_row_index, 0);
    chk({tag, " dense_type_out"}, 32'(dense_type_out), 0);
    chk({tag, " act_type_out"}, 32'(act_type_out), 0);
  endtask
  initial begin
    reset = 1; start = 0; issue_ready = 0; result_valid = 0;
    layer_index = 0; row_count = 0; dense_type = 0; act_type = 0;
    tick; tick;
    reset = 0;
    chk_reset_vals("por");
`ifdef DENSE_SCHED_ERR_EN
    chk("por err", 32'(err), 0);
`endif
    // basic run: 3 rows, returns two cycles after each fire
    layer_index = 7; row_count = 3; dense_type = 5; act_type = 9; issue_ready = 1; start = 1;
    tick;
    start = 0;
    chk("basic busy", 32'(busy), 1);
    chk("basic valid0", 32'(issue_valid), 1);
    chk("basic row0", w_row_index, 0);
    chk("basic layer", w_layer_index, 7);
    chk("basic dense", 32'(dense_type_out), 5);
    chk("basic act", 32'(act_type_out), 9);
    tick;
    chk("basic row1", w_row_index, 1);
    chk("basic inf1", 32'(inflight), 1);
    tick;
    chk("basic row2", w_row_index, 2);
    chk("basic inf2", 32'(inflight), 2);
    result_valid = 1;
    tick;
    chk("basic drain valid", 32'(issue_valid), 0);
    chk("basic fire+ret inf", 32'(inflight), 2);
    chk("basic row held", w_row_index, 2);
    tick;
    chk("basic inf drain", 32'(inflight), 1);
    chk("basic no early done", 32'(done), 0);
    tick;
    chk("basic done", 32'(done), 1);
    chk("basic inf0", 32'(inflight), 0);
    result_valid = 0;
    tick;
    chk("basic done pulse", 32'(done), 0);
    chk("basic idle busy", 32'(busy), 0);
    chk("basic idle row", w_row_index, 2);
    chk("basic idle layer", w_layer_index, 7);
    // backpressure, ignored start, simultaneous fire and return
    layer_index = 3; row_count = 2; dense_type = 4'hA; act_type = 4'h3; start = 1;
    tick;
    start = 0;
    tick;
    chk("bp row1", w_row_index, 1);
    chk("bp inf1", 32'(inflight), 1);
    issue_ready = 0; start = 1; layer_index = 99; row_count = 50; dense_type = 1; act_type = 1;
    tick;
    start = 0;
    chk("bp stall valid", 32'(issue_valid), 1);
    chk("bp stall row", w_row_index, 1);
    chk("bp stall layer", w_layer_index, 3);
    chk("bp stall dense", 32'(dense_type_out), 10);
    chk("bp stall act", 32'(act_type_out), 3);
    tick;
    chk("bp stall row2", w_row_index, 1);
    chk("bp stall inf", 32'(inflight), 1);
    issue_ready = 1; result_valid = 1;
    tick;
    chk("bp fire+ret inf", 32'(inflight), 1);
    chk("bp drain valid", 32'(issue_valid), 0);
    tick;
    chk("bp done", 32'(done), 1);
    chk("bp inf0", 32'(inflight), 0);
    result_valid = 0;
    tick;
    chk("bp idle", 32'(busy), 0);
    // zero rows
    layer_index = 11; row_count = 0; start = 1;
    tick;
    start = 0;
    chk("zero done", 32'(done), 1);
    chk("zero valid", 32'(issue_valid), 0);
    chk("zero busy", 32'(busy), 1);
    chk("zero layer", w_layer_index, 11);
    tick;
    chk("zero done pulse", 32'(done), 0);
    chk("zero idle", 32'(busy), 0);
    // credit limit: 6 rows, no returns
    layer_index = 2; row_count = 6; dense_type = 6; act_type = 2; start = 1;
    tick;
    start = 0;
    tick; tick; tick; tick;
    chk("credit inf4", 32'(inflight), 4);
    chk("credit valid0", 32'(issue_valid), 0);
    chk("credit row4", w_row_index, 4);
    tick;
    chk("credit hold inf", 32'(inflight), 4);
    chk("credit hold row", w_row_index, 4);
    result_valid = 1;
    tick;
    result_valid = 0;
    chk("credit ret inf", 32'(inflight), 3);
    chk("credit ret valid", 32'(issue_valid), 1);
    tick;
    chk("credit fire row4", w_row_index, 5);
    chk("credit refill inf", 32'(inflight), 4);
    chk("credit refill valid", 32'(issue_valid), 0);
    issue_ready = 0; result_valid = 1;
    tick;
    result_valid = 0;
    chk("mid inf3", 32'(inflight), 3);
    chk("mid busy", 32'(busy), 1);
    // reset mid-layer, then a stray return
    reset = 1;
    tick;
    reset = 0;
    chk_reset_vals("midrst");
    result_valid = 1;
    tick;
    result_valid = 0;
    chk("stray inf", 32'(inflight), 0);
    chk("stray busy", 32'(busy), 0);
`ifdef DENSE_SCHED_ERR_EN
    chk("stray err", 32'(err), 1);
`endif
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
